// File: rtl/hazard_ctrl_param.sv
// hazard_ctrl_param
// Pipeline hazard detector for a MIPS 5-stage pipeline with ID-stage branch
// resolution. In-flight register writers are tracked in a shift-register
// scoreboard, so the load latency, the branch window and the flush depth are
// all parameters instead of fixed ID/EX and EX/MEM taps.
//
// Optional feature: define HAZARD_STATS_EN to build the saturating stall and
// flush statistics counters. When it is undefined no counter flops exist and
// o_stall_cnt / o_flush_cnt are tied to zero.
//
// Parameter constraints: TRACK_DEPTH >= BR_WINDOW, TRACK_DEPTH >= LOAD_LAT+1,
// 1 <= FLUSH_SLOTS <= 7.
module hazard_ctrl_param #(
  parameter int REG_AW      = 5,
  parameter int TRACK_DEPTH = 4,
  parameter int LOAD_LAT    = 1,
  parameter int BR_WINDOW   = 2,
  parameter int FLUSH_SLOTS = 1,
  parameter int CNT_W       = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_id_valid,
  input  logic [5:0]        i_op_code,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  input  logic [REG_AW-1:0] i_id_dest,
  input  logic              i_id_reg_write,
  input  logic              i_id_mem_read,
  input  logic              i_equal,
  input  logic              i_not_equal,
  output logic              o_pc_ld,
  output logic              o_if_id_write,
  output logic              o_nop,
  output logic              o_flush,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;

  // Counter value loaded on a redirect: the redirect cycle itself is the first
  // flush slot, the counter covers the remaining ones.
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_SLOTS - 1);

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_FLUSHING = 1'b1
  } state_t;

  // Scoreboard: entry 0 is the instruction that just left ID, entry
  // TRACK_DEPTH-1 is the oldest one still tracked.
  logic [TRACK_DEPTH-1:0]             r_sb_valid;
  logic [TRACK_DEPTH-1:0]             r_sb_rw;
  logic [TRACK_DEPTH-1:0]             r_sb_ld;
  logic [TRACK_DEPTH-1:0][REG_AW-1:0] r_sb_dest;

  logic [TRACK_DEPTH-1:0]             w_sb_valid_next;
  logic [TRACK_DEPTH-1:0]             w_sb_rw_next;
  logic [TRACK_DEPTH-1:0]             w_sb_ld_next;
  logic [TRACK_DEPTH-1:0][REG_AW-1:0] w_sb_dest_next;

  logic [TRACK_DEPTH-1:0] w_match;
  logic [TRACK_DEPTH-1:0] w_lu_hit;
  logic [TRACK_DEPTH-1:0] w_br_hit;

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_fcnt;
  logic [2:0] w_fcnt_next;

  logic w_idv;
  logic w_is_beq;
  logic w_is_bne;
  logic w_is_j;
  logic w_is_branch;
  logic w_load_use;
  logic w_br_hazard;
  logic w_stall;
  logic w_redirect;
  logic w_sb_load;

  // ---------------------------------------------------------------------------
  // Decode and qualification
  // ---------------------------------------------------------------------------

  // While flush slots remain, whatever sits in IF/ID is on the wrong path and
  // is treated as if it were not there at all.
  assign w_idv       = i_id_valid & (r_fcnt == 3'd0);
  assign w_is_beq    = (i_op_code == OP_BEQ);
  assign w_is_bne    = (i_op_code == OP_BNE);
  assign w_is_j      = (i_op_code == OP_J);
  assign w_is_branch = w_is_beq | w_is_bne;

  // ---------------------------------------------------------------------------
  // Per-entry dependency match and hazard windows
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < TRACK_DEPTH; gi++) begin : g_match
      // $zero is hard-wired, so a pending write to it never creates a hazard.
      assign w_match[gi] = r_sb_valid[gi] & r_sb_rw[gi] &
                           (r_sb_dest[gi] != '0) &
                           ((r_sb_dest[gi] == i_id_rs) | (r_sb_dest[gi] == i_id_rt));

      // A load result is not forwardable to ID until LOAD_LAT cycles after it
      // left ID.
      if (gi < LOAD_LAT) begin : g_lu
        assign w_lu_hit[gi] = w_match[gi] & r_sb_ld[gi];
      end else begin : g_no_lu
        assign w_lu_hit[gi] = 1'b0;
      end

      // A branch compares in ID, so any writer inside the branch window blocks
      // it, and a load blocks it one cycle longer than a normal consumer.
      if (gi < BR_WINDOW) begin : g_br
        assign w_br_hit[gi] = w_match[gi];
      end else if (gi < LOAD_LAT + 1) begin : g_br_ld
        assign w_br_hit[gi] = w_match[gi] & r_sb_ld[gi];
      end else begin : g_no_br
        assign w_br_hit[gi] = 1'b0;
      end
    end
  endgenerate

  assign w_load_use  = |w_lu_hit;
  assign w_br_hazard = w_is_branch & (|w_br_hit);
  assign w_stall     = w_idv & (w_load_use | w_br_hazard);

  // A stalled instruction never redirects; it re-evaluates next cycle.
  assign w_redirect  = w_idv & ~w_stall &
                       (w_is_j | (w_is_beq & i_equal) | (w_is_bne & i_not_equal));

  // Only an instruction that actually advances out of ID becomes a tracked
  // entry; stalls and squashed slots shift in a bubble.
  assign w_sb_load   = w_idv & ~w_stall;

  // ---------------------------------------------------------------------------
  // Scoreboard shift register
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < TRACK_DEPTH; gi++) begin : g_sb_next
      if (gi == 0) begin : g_head
        assign w_sb_valid_next[gi] = w_sb_load;
        assign w_sb_rw_next[gi]    = i_id_reg_write;
        assign w_sb_ld_next[gi]    = i_id_mem_read;
        assign w_sb_dest_next[gi]  = i_id_dest;
      end else begin : g_body
        assign w_sb_valid_next[gi] = r_sb_valid[gi-1];
        assign w_sb_rw_next[gi]    = r_sb_rw[gi-1];
        assign w_sb_ld_next[gi]    = r_sb_ld[gi-1];
        assign w_sb_dest_next[gi]  = r_sb_dest[gi-1];
      end
    end
  endgenerate

  // Advance every scoreboard entry by one slot each clock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sb_valid <= '0;
      r_sb_rw    <= '0;
      r_sb_ld    <= '0;
      r_sb_dest  <= '0;
    end else begin
      r_sb_valid <= w_sb_valid_next;
      r_sb_rw    <= w_sb_rw_next;
      r_sb_ld    <= w_sb_ld_next;
      r_sb_dest  <= w_sb_dest_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Flush FSM
  // ---------------------------------------------------------------------------

  // Hold the flush state and the count of remaining flush slots.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_fcnt  <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_fcnt  <= w_fcnt_next;
    end
  end

  // Start a flush burst on a redirect and count down its extra slots.
  always_comb begin
    w_state_next = r_state;
    w_fcnt_next  = r_fcnt;
    case (r_state)
      S_IDLE: begin
        if (w_redirect) begin
          w_fcnt_next = FLUSH_INIT;
          if (FLUSH_INIT != 3'd0) begin
            w_state_next = S_FLUSHING;
          end
        end
      end
      S_FLUSHING: begin
        w_fcnt_next = r_fcnt - 3'd1;
        if (r_fcnt == 3'd1) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_fcnt_next  = 3'd0;
      end
    endcase
  end

  // Drive stall controls from the hazard decision and flush from the FSM.
  always_comb begin
    o_pc_ld       = 1'b1;
    o_if_id_write = 1'b1;
    o_nop         = 1'b0;
    o_flush       = 1'b0;
    if (w_stall) begin
      o_pc_ld       = 1'b0;
      o_if_id_write = 1'b0;
      o_nop         = 1'b1;
    end
    case (r_state)
      S_IDLE:     o_flush = w_redirect;
      S_FLUSHING: o_flush = 1'b1;
      default:    o_flush = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Count stall cycles and redirect events, saturating at all-ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_redirect && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

  // Match bits and load flags outside every hazard window are intentionally
  // not consumed.
  logic w_unused;
  assign w_unused = ^{w_match, r_sb_ld};

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Directed bench for hazard_ctrl_param. Two instances: dut_a uses the default
// parameters (single flush slot, 16-bit counters), dut_b uses FLUSH_SLOTS=3
// and CNT_W=4 for the multi-slot flush and saturation cases. Expected counter
// values depend on whether HAZARD_STATS_EN is defined for the build.
module tb_hazard_ctrl_param;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;

  // Output bundle {pc_ld, IF_ID_write, nop, flush}
  localparam logic [3:0] RUN = 4'b1100;
  localparam logic [3:0] STL = 4'b0010;
  localparam logic [3:0] FLS = 4'b1101;

`ifdef HAZARD_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       id_valid     [2];
  logic [5:0] op_code      [2];
  logic [4:0] id_rs        [2];
  logic [4:0] id_rt        [2];
  logic [4:0] id_dest      [2];
  logic       id_reg_write [2];
  logic       id_mem_read  [2];
  logic       equal        [2];
  logic       not_equal    [2];
  logic       pc_ld        [2];
  logic       if_id_write  [2];
  logic       nop          [2];
  logic       flush        [2];

  logic [15:0] stall_cnt_a;
  logic [15:0] flush_cnt_a;
  logic [3:0]  stall_cnt_b;
  logic [3:0]  flush_cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_param dut_a (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_id_valid     (id_valid[0]),
    .i_op_code      (op_code[0]),
    .i_id_rs        (id_rs[0]),
    .i_id_rt        (id_rt[0]),
    .i_id_dest      (id_dest[0]),
    .i_id_reg_write (id_reg_write[0]),
    .i_id_mem_read  (id_mem_read[0]),
    .i_equal        (equal[0]),
    .i_not_equal    (not_equal[0]),
    .o_pc_ld        (pc_ld[0]),
    .o_if_id_write  (if_id_write[0]),
    .o_nop          (nop[0]),
    .o_flush        (flush[0]),
    .o_stall_cnt    (stall_cnt_a),
    .o_flush_cnt    (flush_cnt_a)
  );

  hazard_ctrl_param #(
    .FLUSH_SLOTS (3),
    .CNT_W       (4)
  ) dut_b (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_id_valid     (id_valid[1]),
    .i_op_code      (op_code[1]),
    .i_id_rs        (id_rs[1]),
    .i_id_rt        (id_rt[1]),
    .i_id_dest      (id_dest[1]),
    .i_id_reg_write (id_reg_write[1]),
    .i_id_mem_read  (id_mem_read[1]),
    .i_equal        (equal[1]),
    .i_not_equal    (not_equal[1]),
    .o_pc_ld        (pc_ld[1]),
    .o_if_id_write  (if_id_write[1]),
    .o_nop          (nop[1]),
    .o_flush        (flush[1]),
    .o_stall_cnt    (stall_cnt_b),
    .o_flush_cnt    (flush_cnt_b)
  );

  function automatic logic [3:0] outs(input int s);
    return {pc_ld[s], if_id_write[s], nop[s], flush[s]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int s, input logic v, input logic [5:0] op,
                     input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dest,
                     input logic rw, input logic mr, input logic eq, input logic ne);
    id_valid[s]     = v;
    op_code[s]      = op;
    id_rs[s]        = rs;
    id_rt[s]        = rt;
    id_dest[s]      = dest;
    id_reg_write[s] = rw;
    id_mem_read[s]  = mr;
    equal[s]        = eq;
    not_equal[s]    = ne;
  endtask

  // Present one ID-stage instruction, check the outputs mid-cycle, then move
  // on to the next falling edge (one rising edge in between).
  task automatic step(input string tag, input int s, input logic v, input logic [5:0] op,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dest,
                      input logic rw, input logic mr, input logic eq, input logic ne,
                      input logic [3:0] exp);
    drv(s, v, op, rs, rt, dest, rw, mr, eq, ne);
    #1;
    chk(tag, 32'(outs(s)), 32'(exp));
    @(negedge clk);
  endtask

  task automatic idle(input int s, input int n);
    drv(s, 1'b0, OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    drv(0, 1'b0, OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(1, 1'b0, OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    chk("reset_out_a",     32'(outs(0)), 32'(RUN));
    chk("reset_out_b",     32'(outs(1)), 32'(RUN));
    chk("reset_stall_a",   32'(stall_cnt_a), 32'd0);
    chk("reset_flush_a",   32'(flush_cnt_a), 32'd0);
    chk("reset_stall_b",   32'(stall_cnt_b), 32'd0);
    chk("reset_flush_b",   32'(flush_cnt_b), 32'd0);
    rst = 1'b0;

    // Load-use: lw $8 then add reading $8 -> exactly one stall cycle
    step("lu_lw",      0, 1, OP_LW, 5'd1, 5'd2, 5'd8,  1, 1, 0, 0, RUN);
    step("lu_stall",   0, 1, OP_R,  5'd8, 5'd3, 5'd10, 1, 0, 0, 0, STL);
    step("lu_resume",  0, 1, OP_R,  5'd8, 5'd3, 5'd10, 1, 0, 0, 0, RUN);
    idle(0, 4);

    // Load two instructions back is already out of the load-use window
    step("gap_lw",     0, 1, OP_LW, 5'd1, 5'd2, 5'd8,  1, 1, 0, 0, RUN);
    step("gap_other",  0, 1, OP_R,  5'd1, 5'd2, 5'd11, 1, 0, 0, 0, RUN);
    step("gap_use",    0, 1, OP_R,  5'd3, 5'd8, 5'd12, 1, 0, 0, 0, RUN);
    idle(0, 4);

    // Load to $0 never creates a dependency
    step("r0_lw",      0, 1, OP_LW, 5'd1, 5'd2, 5'd0,  1, 1, 0, 0, RUN);
    step("r0_use",     0, 1, OP_R,  5'd0, 5'd0, 5'd13, 1, 0, 0, 0, RUN);
    idle(0, 4);

    // Branch after R-type: two stall cycles, then taken with a single flush
    step("br_add",     0, 1, OP_R,   5'd1, 5'd2, 5'd9, 1, 0, 0, 0, RUN);
    step("br_stall1",  0, 1, OP_BEQ, 5'd9, 5'd5, 5'd0, 0, 0, 1, 0, STL);
    step("br_stall2",  0, 1, OP_BEQ, 5'd9, 5'd5, 5'd0, 0, 0, 1, 0, STL);
    step("br_taken",   0, 1, OP_BEQ, 5'd9, 5'd5, 5'd0, 0, 0, 1, 0, FLS);
    chk("br_stall_cnt", 32'(stall_cnt_a), (STATS != 0) ? 32'd3 : 32'd0);
    chk("br_flush_cnt", 32'(flush_cnt_a), (STATS != 0) ? 32'd1 : 32'd0);
    step("br_post",    0, 1, OP_R,   5'd1, 5'd2, 5'd0, 0, 0, 0, 0, RUN);
    idle(0, 4);

    // Writer in the last entry of the branch window, then just outside it
    step("win_add",    0, 1, OP_R,   5'd1, 5'd2, 5'd9,  1, 0, 0, 0, RUN);
    step("win_other",  0, 1, OP_R,   5'd1, 5'd2, 5'd14, 1, 0, 0, 0, RUN);
    step("win_edge",   0, 1, OP_BNE, 5'd9, 5'd0, 5'd0,  0, 0, 0, 1, STL);
    step("win_clear",  0, 1, OP_BEQ, 5'd9, 5'd0, 5'd0,  0, 0, 0, 1, RUN);
    idle(0, 4);

    // Branch after load: two stalls with not_equal held, flush only afterwards
    step("ldbr_lw",    0, 1, OP_LW,  5'd1, 5'd2, 5'd4, 1, 1, 0, 0, RUN);
    step("ldbr_st1",   0, 1, OP_BNE, 5'd7, 5'd4, 5'd0, 0, 0, 0, 1, STL);
    step("ldbr_st2",   0, 1, OP_BNE, 5'd7, 5'd4, 5'd0, 0, 0, 0, 1, STL);
    step("ldbr_take",  0, 1, OP_BNE, 5'd7, 5'd4, 5'd0, 0, 0, 0, 1, FLS);
    chk("ldbr_stall_cnt", 32'(stall_cnt_a), (STATS != 0) ? 32'd6 : 32'd0);
    idle(0, 4);

    // Jump with one flush slot: next instruction proceeds normally
    step("j_taken",    0, 1, OP_J,   5'd0, 5'd0, 5'd0, 0, 0, 0, 0, FLS);
    step("j_next",     0, 1, OP_R,   5'd1, 5'd2, 5'd0, 0, 0, 0, 0, RUN);
    chk("j_flush_cnt", 32'(flush_cnt_a), (STATS != 0) ? 32'd3 : 32'd0);
    idle(0, 2);

    // FLUSH_SLOTS=3: jump flushes 3 cycles; squashed jumps / hazards ignored
    step("m_j",        1, 1, OP_J,   5'd0, 5'd0, 5'd8, 1, 1, 0, 0, FLS);
    step("m_slot2",    1, 1, OP_J,   5'd8, 5'd0, 5'd8, 1, 1, 0, 0, FLS);
    step("m_slot3",    1, 1, OP_J,   5'd8, 5'd0, 5'd8, 1, 0, 0, 0, FLS);
    step("m_after",    1, 1, OP_BEQ, 5'd8, 5'd1, 5'd0, 0, 0, 0, 1, RUN);
    chk("m_flush_cnt", 32'(flush_cnt_b), (STATS != 0) ? 32'd1 : 32'd0);
    chk("m_stall_cnt", 32'(stall_cnt_b), 32'd0);
    idle(1, 2);

    // Saturation of a 4-bit stall counter
    for (int i = 0; i < 14; i++) begin
      step("sat_lw",   1, 1, OP_LW, 5'd1, 5'd2, 5'd8,  1, 1, 0, 0, RUN);
      step("sat_st",   1, 1, OP_R,  5'd8, 5'd3, 5'd10, 1, 0, 0, 0, STL);
      step("sat_go",   1, 1, OP_R,  5'd8, 5'd3, 5'd10, 1, 0, 0, 0, RUN);
    end
    chk("sat_cnt14", 32'(stall_cnt_b), (STATS != 0) ? 32'd14 : 32'd0);
    for (int i = 0; i < 6; i++) begin
      step("sat_lw",   1, 1, OP_LW, 5'd1, 5'd2, 5'd8,  1, 1, 0, 0, RUN);
      step("sat_st",   1, 1, OP_R,  5'd8, 5'd3, 5'd10, 1, 0, 0, 0, STL);
      step("sat_go",   1, 1, OP_R,  5'd8, 5'd3, 5'd10, 1, 0, 0, 0, RUN);
    end
    chk("sat_cnt15", 32'(stall_cnt_b), (STATS != 0) ? 32'd15 : 32'd0);

    // Asynchronous reset in the middle of a flush burst
    step("rst_j",      1, 1, OP_J,   5'd0, 5'd0, 5'd8, 1, 1, 0, 0, FLS);
    chk("rst_pre_flush_cnt", 32'(flush_cnt_b), (STATS != 0) ? 32'd2 : 32'd0);
    drv(1, 1, OP_R, 5'd8, 5'd0, 5'd9, 1, 0, 0, 0);
    #1;
    chk("rst_flushing", 32'(outs(1)), 32'(FLS));
    #1 rst = 1'b1;
    #1;
    chk("rst_async_out_b", 32'(outs(1)), 32'(RUN));
    chk("rst_async_out_a", 32'(outs(0)), 32'(RUN));
    chk("rst_stall_cnt_b", 32'(stall_cnt_b), 32'd0);
    chk("rst_flush_cnt_b", 32'(flush_cnt_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_release_nostall", 32'(outs(1)), 32'(RUN));
    @(negedge clk);
    idle(1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_param.md
Name: hazard_ctrl_param

Overview:
- Parametrised successor to the pipeline hazard detector.
- Tracks in-flight register writers in a scoreboard shift register instead of relying on fixed ID/EX and EX/MEM taps.
- Generates stall (pc_ld, if_id_write, nop) and multi-cycle flush for a MIPS 5-stage pipeline with ID-stage branch resolution.
- Supports configurable load latency, branch window and flush depth, and optional hazard statistics counters.

Parameters:
- REG_AW, 5: register address width.
- TRACK_DEPTH, 4: scoreboard entries (instructions in flight past ID); must be at least BR_WINDOW and at least LOAD_LAT+1.
- LOAD_LAT, 1: cycles a load's result is unavailable to ID after the load leaves ID.
- BR_WINDOW, 2: scoreboard entries (0..BR_WINDOW-1) whose pending writes block an ID-stage branch compare.
- FLUSH_SLOTS, 1: cycles flush stays asserted per taken branch/jump (1..7).
- CNT_W, 16: statistics counter width.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous active-high reset.
- id_valid, input, 1: IF/ID holds a real instruction.
- op_code, input, 6: ID opcode; BEQ=000100, BNE=000101, J=000010 decoded internally.
- id_rs, input, REG_AW: ID source register rs.
- id_rt, input, REG_AW: ID source register rt.
- id_dest, input, REG_AW: ID instruction's destination register.
- id_reg_write, input, 1: ID instruction writes the register file.
- id_mem_read, input, 1: ID instruction is a load.
- equal, input, 1: ID comparator, rs==rt.
- not_equal, input, 1: ID comparator, rs!=rt.
- pc_ld, output, 1: PC load enable.
- IF_ID_write, output, 1: IF/ID register write enable.
- nop, output, 1: insert bubble into ID/EX.
- flush, output, 1: squash IF/ID contents.
- stall_cnt, output, CNT_W: stall cycle count.
- flush_cnt, output, CNT_W: flush event count.

Behaviour:
- Reset (async, immediate): all scoreboard entries invalid, flush counter 0, stats 0.
- Reset outputs: pc_ld=1, IF_ID_write=1, nop=0, flush=0.
- Effective ID valid: idv = id_valid AND flush counter == 0. A squashed instruction never stalls, never flushes and never enters the scoreboard.
- Scoreboard entry fields: {valid, dest, rw, ld}. Shifts every clock: entry i moves to i+1, entry TRACK_DEPTH-1 is discarded.
- Entry 0 load: {1, id_dest, id_reg_write, id_mem_read} when idv and not stall; otherwise a bubble (valid=0).
- Match(i): entry i valid AND rw AND dest != 0 AND (dest == id_rs OR dest == id_rt). Register 0 never matches.
- Load-use stall (any instruction): Match(i) with ld=1 for some i < LOAD_LAT.
- Branch stall (BEQ/BNE only): Match(i) for some i < BR_WINDOW, or Match(i) with ld=1 for some i < LOAD_LAT+1.
- stall = idv AND (load-use OR branch). Combinational. Gives pc_ld=0, IF_ID_write=0, nop=1.
- Redirect = idv AND NOT stall AND (J OR (BEQ AND equal) OR (BNE AND not_equal)). Stall always suppresses redirect for every opcode.
- Flush FSM, state IDLE:
  - flush = redirect (same cycle).
  - On redirect, load counter with FLUSH_SLOTS-1; go to FLUSHING if that value is nonzero.
- Flush FSM, state FLUSHING:
  - flush=1; counter decrements each cycle; return to IDLE when it reaches 0.
  - pc_ld=1 and IF_ID_write=1 during FLUSHING.
- Total flush assertion per redirect is exactly FLUSH_SLOTS cycles.
- A redirect already in ID during FLUSHING is squashed; no re-trigger.
- Simultaneous stall and branch taken: stall wins, no flush. The branch re-evaluates on the following cycle.
- Counters, when enabled:
  - stall_cnt increments once per stall cycle.
  - flush_cnt increments once per redirect event, not per flush cycle.
  - Both saturate at all-ones; no wrap.

Optional Feature:
- HAZARD_STATS_EN defined: stall_cnt/flush_cnt registers implemented as above.
- HAZARD_STATS_EN undefined: no counter flops; stall_cnt and flush_cnt tied to 0.

Test Plan:
- Load-use: lw $8 enters entry 0; next ID is add reading rs=8 -> exactly 1 stall cycle (pc_ld=0, IF_ID_write=0, nop=1), then normal. Same sequence with dest=$0 -> no stall.
- Branch after R-type, BR_WINDOW=2: add $9 then beq rs=9 -> 2 stall cycles, then beq with equal=1 -> flush=1 for 1 cycle, flush_cnt=1, stall_cnt=2.
- Branch after load, LOAD_LAT=1: lw $4 then bne rt=4 -> 2 stall cycles; not_equal=1 while stalled -> flush stays 0 until stall clears.
- FLUSH_SLOTS=3: J -> flush high exactly 3 cycles. A second J presented in ID during cycles 2-3 -> ignored, flush_cnt=1.
- Saturation, CNT_W=4: force 20 stall cycles -> stall_cnt=15 and holds.
- Async reset: assert rst mid-FLUSHING with a valid load in entry 0 -> flush=0 and pc_ld=1 immediately; after release the dependent instruction does not stall.
